// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and FSM state codes.
// The decoder and hazard unit import the op codes from here.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// The result is computed at launch and held in pending registers until the counter expires.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] mdu_op,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pendHi_q, pendHi_d;
  logic [WIDTH-1:0] pendLo_q, pendLo_d;
  logic             pendWr_q, pendWr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic signed [2*WIDTH-1:0] prodS;
  logic        [2*WIDTH-1:0] prodU;
  logic signed [WIDTH-1:0]   quotS, remS;
  logic        [WIDTH-1:0]   quotU, remU;
  logic                      divOverflow;

  assign prodS = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign prodU = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign quotS = $signed(A) / $signed(B);
  assign remS  = $signed(A) % $signed(B);
  assign quotU = A / B;
  assign remU  = A % B;

  // MIN_NEG / -1 does not fit in WIDTH bits, so it is pinned to lo=MIN_NEG, hi=0.
  assign divOverflow = (A == MIN_NEG) && (B == {WIDTH{1'b1}});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pendHi_d = pendHi_q;
    pendLo_d = pendLo_q;
    pendWr_d = pendWr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    if (state_q == ST_IDLE) begin
      if (start) begin
        case (mdu_op)
          MDU_MULT, MDU_MULTU: begin
            {pendHi_d, pendLo_d} = (mdu_op == MDU_MULT) ? prodS : prodU;
            pendWr_d = 1'b1;
            cnt_d    = CNT_MULT;
            state_d  = ST_BUSY;
          end
          MDU_DIV: begin
            pendWr_d = (B != '0);
            pendHi_d = divOverflow ? '0 : remS;
            pendLo_d = divOverflow ? MIN_NEG : quotS;
            cnt_d    = CNT_DIV;
            state_d  = ST_BUSY;
          end
          MDU_DIVU: begin
            pendWr_d = (B != '0);
            pendHi_d = remU;
            pendLo_d = quotU;
            cnt_d    = CNT_DIV;
            state_d  = ST_BUSY;
          end
          MDU_MTHI: hi_d = A;
          MDU_MTLO: lo_d = A;
          default: ;
        endcase
      end
    end else begin
      // Divide by zero still runs the full latency but leaves HI/LO untouched.
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (pendWr_q) begin
          hi_d = pendHi_q;
          lo_d = pendLo_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pendHi_q <= '0;
      pendLo_q <= '0;
      pendWr_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pendHi_q <= pendHi_d;
      pendLo_q <= pendLo_d;
      pendWr_q <= pendWr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu with WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
module tb_mdu;
  import mdu_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [MDU_OP_W-1:0] mdu_op = '0;
  logic [31:0]         A = '0;
  logic [31:0]         B = '0;
  logic                busy;
  logic                done;
  logic [31:0]         hi;
  logic [31:0]         lo;

  int total = 0;
  int bad   = 0;

  mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one start pulse across a single rising edge; returns at the following falling edge.
  task automatic applyStimulus(input logic [MDU_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 3'd7;
  endtask

  task automatic waitDone(input string tag, input int expCycles);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_busycyc"}, 32'(n), 32'(expCycles));
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    checkOutput({tag, "_donefall"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int sawActivity;

    repeat (3) @(negedge clk);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    applyStimulus(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    waitDone("mult", 5);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFF1);

    applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    waitDone("multu", 5);
    checkOutput("multu_hi", hi, 32'h0000_0001);
    checkOutput("multu_lo", lo, 32'hFFFF_FFFE);

    applyStimulus(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone("div", 10);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);

    applyStimulus(MDU_DIVU, 32'd7, 32'd2);
    waitDone("divu", 10);
    checkOutput("divu_lo", lo, 32'd3);
    checkOutput("divu_hi", hi, 32'd1);

    applyStimulus(MDU_MTHI, 32'h0000_1234, 32'd0);
    checkOutput("mthi_hi", hi, 32'h0000_1234);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    checkOutput("mthi_done", {31'd0, done}, 32'd0);
    applyStimulus(MDU_MTLO, 32'h0000_5678, 32'd0);
    checkOutput("mtlo_lo", lo, 32'h0000_5678);
    checkOutput("mtlo_hi", hi, 32'h0000_1234);

    applyStimulus(MDU_DIVU, 32'd99, 32'd0);
    waitDone("div0", 10);
    checkOutput("div0_hi", hi, 32'h0000_1234);
    checkOutput("div0_lo", lo, 32'h0000_5678);

    applyStimulus(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("ovf", 10);
    checkOutput("ovf_lo", lo, 32'h8000_0000);
    checkOutput("ovf_hi", hi, 32'd0);

    // Start while busy: MTLO and DIV must both be dropped.
    applyStimulus(MDU_MULT, 32'd2, 32'd3);
    n = 1;
    start  = 1'b1;
    mdu_op = MDU_MTLO;
    A      = 32'h0000_00AA;
    @(negedge clk);
    if (busy === 1'b1) n++;
    mdu_op = MDU_DIV;
    A      = 32'd100;
    B      = 32'd7;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 3'd7;
    while (busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    checkOutput("ign_busycyc", 32'(n), 32'd5);
    checkOutput("ign_done", {31'd0, done}, 32'd1);
    checkOutput("ign_hi", hi, 32'd0);
    checkOutput("ign_lo", lo, 32'd6);
    @(negedge clk);
    checkOutput("ign_nobusy", {31'd0, busy}, 32'd0);

    // Reset mid-divide aborts without any later commit.
    applyStimulus(MDU_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sawActivity = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) sawActivity = 1;
    end
    checkOutput("abort_quiet", 32'(sawActivity), 32'd0);
    checkOutput("abort_lo_after", lo, 32'd0);

    applyStimulus(MDU_MULT, 32'd4, 32'd4);
    waitDone("post", 5);
    checkOutput("post_lo", lo, 32'd16);
    checkOutput("post_hi", hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It sits in the EX stage beside the single-cycle ALU and executes mult/multu/div/divu over a fixed cycle count, plus mthi/mtlo writes. It drives `busy` so the hazard unit stalls any MDU-dependent instruction until the result is committed.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 2.
- `MULT_CYCLES`, 5: busy cycles for a multiply; must be ≥ 1.
- `DIV_CYCLES`, 10: busy cycles for a divide; must be ≥ 1.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: launch the operation on `mdu_op` with operands `A`, `B`.
- `mdu_op`  in  3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op.
- `A`  in  WIDTH: first operand (dividend; source for MTHI/MTLO).
- `B`  in  WIDTH: second operand (divisor).
- `busy`  out  1: operation in flight.
- `done`  out  1: one-cycle pulse in the cycle after HI/LO commit.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- States are IDLE and BUSY, tracked with a down-counter `cnt` of width clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.
- **In IDLE, when `start`=1 at an edge:**
  - MULT/MULTU: latch the full 2·WIDTH product of A×B (signed or unsigned) into pending registers. Set `cnt` to MULT_CYCLES and go to BUSY.
  - DIV/DIVU: latch quotient and remainder. Set `cnt` to DIV_CYCLES and go to BUSY.
  - MTHI/MTLO: write A into `hi`/`lo` at that edge. Stay in IDLE. `busy` stays 0 and `done` stays 0.
  - Ops 6–7: ignored.
- **In BUSY:** `cnt` decrements each edge. At the edge where `cnt` goes 1→0:
  - `hi` takes the upper product half or the remainder.
  - `lo` takes the lower product half or the quotient.
  - The state returns to IDLE.
- **Start while busy:** `start` is ignored, including MTHI/MTLO. Pending operands are never overwritten.
- **Signed divide:** truncates toward zero; the remainder takes the sign of the dividend.
  - Example, WIDTH=32: −7/2 gives lo=−3, hi=−1.
- **Signed overflow:** −2^(WIDTH−1) / −1 gives lo=−2^(WIDTH−1), hi=0.
- **Divide by zero:** the unit goes busy for DIV_CYCLES and pulses `done`. `hi` and `lo` are left unchanged.
- **Width rules:** the product is exact in 2·WIDTH bits. MULTU/DIVU treat operands as unsigned.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, `cnt`=0. Reset asserted mid-operation aborts it immediately with no commit.
- **Launch:** with `start` sampled at edge E0, `busy`=1 from just after E0 through edge E_N, where N = MULT_CYCLES or DIV_CYCLES. That is exactly N cycles high.
- **Commit:** at E_N, `hi`/`lo` update, `busy` falls and `done` rises for one cycle. Result is readable in the cycle after E_N.
- **Back-to-back:** the next `start` is accepted at E_N+1, giving minimum issue spacing of N+1 cycles.
- **MTHI/MTLO:** zero-latency register write. The new value is visible in the cycle after the edge.
- **Outputs:** `busy` and `done` are registered, with no combinational path from `start`.

## Structure
- Shared package `mdu_pkg`:
  - `mdu_op` encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - Op width constant MDU_OP_W = 3.
  - State encoding IDLE/BUSY.
- The decoder and hazard unit import the op codes from `mdu_pkg`.
- No sub-module. The single FSM, counter and pending registers sit in `mdu`. Arithmetic uses behavioural operators.

## Test plan
- MULT, A=−3 (0xFFFFFFFD), B=5, WIDTH=32, MULT_CYCLES=5 -> `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, `done` one-cycle pulse.
- MULTU, A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV, A=−7, B=2, DIV_CYCLES=10 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, A=7, B=2 -> lo=3, hi=1.
- Preload via MTHI 0x1234 and MTLO 0x5678, then DIVU with B=0 -> `busy` for 10 cycles, `done` pulses, hi=0x1234, lo=0x5678 unchanged. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue MULT 2×3, then assert `start` with MTLO 0xAA and DIV at cycle 2 while busy -> both ignored; hi=0, lo=6; `busy` never extends past 5 cycles.
- Start DIV 100/7, then assert `reset` at busy cycle 4 -> `hi`, `lo`, `busy`, `done` all 0 immediately, and no commit after reset release. A fresh MULT 4×4 then yields lo=16.
